// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory interface types used by the pipeline, memory_control and RAM models.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/ram_responder_pkg.sv
// Constants and FSM encoding for the latency-configurable RAM responder.
package ram_responder_pkg;
  localparam int RAM_LAT_MAX = 15;
  localparam int RAM_CNT_W   = $clog2(RAM_LAT_MAX + 1);

  typedef enum logic {
    RAM_IDLE = 1'b0,
    RAM_WAIT = 1'b1
  } ram_fsm_t;
endpackage

// File: rtl/ram_array.sv
// Single-port word array: asynchronous read, synchronous write, contents not reset.
module ram_array #(
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);
  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ram_responder.sv
// RAM-side responder for cpu_ram_if: BUSY for LAT cycles, then one ACCESS cycle per request.
// Handshake: a request held stable (addr/op/data) sees BUSY until ACCESS; ACCESS completes it.
module ram_responder
  import cpu_types_pkg::*;
  import ram_responder_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memstore,
  input  logic              memREN,
  input  logic              memWEN,
  output logic [31:0]       ramload,
  output ramstate_t         ramstate,
  input  logic              dbg_WEN,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_store
);
  localparam logic [RAM_CNT_W-1:0] C_LAT_LAST = RAM_CNT_W'((LAT > 0) ? LAT - 1 : 0);

  ram_fsm_t               r_state, w_state_nx;
  logic [RAM_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_wr;
  logic [31:0]            r_data;
  logic [31:0]            r_ramload;
  logic                   w_load;
  logic                   w_access;

  logic [ADDR_W-1:0] w_idx;
  logic              w_any, w_aligned, w_inrange, w_err, w_req, w_same, w_last;
  logic              w_access_rd, w_access_wr;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_addr;
  logic [31:0]       w_arr_wdata, w_rdata;

  assign w_idx     = memaddr[ADDR_W+1:2];
  assign w_any     = memREN | memWEN;
  assign w_aligned = (memaddr[1:0] == 2'b00);
  assign w_inrange = ((memaddr >> (ADDR_W + 2)) == 32'd0);
  assign w_err     = !dbg_WEN && ((memREN && memWEN) || (w_any && !(w_aligned && w_inrange)));
  assign w_req     = !dbg_WEN && (memREN ^ memWEN) && w_aligned && w_inrange;
  // Any change of address, op or write data abandons the in-flight request.
  assign w_same    = w_req && (w_idx == r_addr) && (memWEN == r_wr) &&
                     (!memWEN || (memstore == r_data));
  assign w_last    = (r_cnt == C_LAT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= RAM_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_data    <= '0;
      r_ramload <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_load) begin
        r_addr <= w_idx;
        r_wr   <= memWEN;
        r_data <= memstore;
      end
      if (w_access_rd) r_ramload <= w_rdata;
    end
  end

  always_comb begin
    w_state_nx = RAM_IDLE;
    w_cnt_nx   = '0;
    w_load     = 1'b0;
    if (!dbg_WEN && !w_err) begin
      case (r_state)
        RAM_IDLE: begin
          if (w_req && (LAT != 0)) begin
            w_state_nx = RAM_WAIT;
            w_load     = 1'b1;
          end
        end
        RAM_WAIT: begin
          if (w_same) begin
            if (!w_last) begin
              w_state_nx = RAM_WAIT;
              w_cnt_nx   = r_cnt + 1'b1;
            end
          end else if (w_req) begin
            w_state_nx = RAM_WAIT;
            w_load     = 1'b1;
          end
        end
        default: w_state_nx = RAM_IDLE;
      endcase
    end
  end

  always_comb begin
    ramstate = FREE;
    w_access = 1'b0;
    if (!nRST) begin
      ramstate = FREE;
    end else if (dbg_WEN) begin
      ramstate = w_any ? BUSY : FREE;
    end else if (w_err) begin
      ramstate = ERROR;
    end else begin
      case (r_state)
        RAM_IDLE: begin
          if (w_req) begin
            if (LAT == 0) w_access = 1'b1;
            else          ramstate = BUSY;
          end
        end
        RAM_WAIT: begin
          if (w_same) begin
            if (w_last) w_access = 1'b1;
            else        ramstate = BUSY;
          end else if (w_req) begin
            ramstate = BUSY;
          end
        end
        default: ramstate = FREE;
      endcase
      if (w_access) ramstate = ACCESS;
    end
  end

  assign w_access_rd = w_access && memREN;
  assign w_access_wr = w_access && memWEN;
  assign ramload     = w_access_rd ? w_rdata : r_ramload;

  // Preload owns the single array port whenever it is active.
  assign w_arr_we    = dbg_WEN || w_access_wr;
  assign w_arr_addr  = dbg_WEN ? dbg_addr  : w_idx;
  assign w_arr_wdata = dbg_WEN ? dbg_store : memstore;

  ram_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (CLK),
    .i_we    (w_arr_we),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_rdata)
  );
endmodule
